// File: rtl/alu_muldiv_if.sv
// Request/response and borrowed-ALU signals between the execute stage and the
// multi-cycle multiply/divide sequencer.
interface alu_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] result;
  logic            alu_own;
  logic [XLEN-1:0] alu_rda;
  logic [XLEN-1:0] alu_rdb;
  logic [3:0]      alu_fop;
  logic [XLEN-1:0] alu_result;

  modport master (
    output start, op, opa, opb, alu_result,
    input  ready, done, result, alu_own, alu_rda, alu_rdb, alu_fop
  );

  modport slave (
    input  start, op, opa, opb, alu_result,
    output ready, done, result, alu_own, alu_rda, alu_rdb, alu_fop
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Unsigned MUL/MULHU/DIVU/REMU sequencer that borrows the shared ALU for XLEN cycles.
// Optional MULDIV_EARLY_OUT_EN: zero operands finish straight from IDLE.
module alu_muldiv_seq #(
  parameter int XLEN    = 32,
  parameter int FOP_ADD = 0,
  parameter int FOP_SUB = 1
) (
  input  logic         clk,
  input  logic         rst,
  alu_muldiv_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic [1:0]      op_q;
  // acc: hi (mul) / rem (div); sh: lo (mul) / quo (div); b: mc (mul) / dv (div)
  logic [XLEN-1:0] acc_q, sh_q, b_q, res_q;
  logic [XLEN-1:0] acc_n, sh_n, sum, early_res;
  logic [XLEN:0]   rs;
  logic            is_div, accept, early, last, ge, carry, own;

  assign is_div = op_q[1];
  assign accept = (state_q == IDLE) && bus.start;
  assign last   = (cnt_q == CW'(XLEN-1));
  assign own    = (state_q == BUSY);

`ifdef MULDIV_EARLY_OUT_EN
  assign early = accept && ((bus.opa == '0) || (bus.opb == '0));
  always_comb begin
    early_res = '0;
    if (bus.op[1]) begin
      if (bus.op[0])           early_res = bus.opa;
      else if (bus.opb == '0)  early_res = '1;
    end
  end
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = early ? DONE : BUSY;
      BUSY:    if (last)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide around the ALU result
  always_comb begin
    rs    = {acc_q, sh_q[XLEN-1]};
    ge    = (rs >= {1'b0, b_q});
    sum   = sh_q[0] ? bus.alu_result : acc_q;
    carry = sh_q[0] && (bus.alu_result < acc_q);
    if (is_div) begin
      acc_n = ge ? bus.alu_result : rs[XLEN-1:0];
      sh_n  = {sh_q[XLEN-2:0], ge};
    end else begin
      acc_n = {carry, sum[XLEN-1:1]};
      sh_n  = {sum[0], sh_q[XLEN-1:1]};
    end
  end

  always_comb begin
    bus.ready   = (state_q == IDLE);
    bus.done    = (state_q == DONE);
    bus.result  = res_q;
    bus.alu_own = own;
    bus.alu_rda = '0;
    bus.alu_rdb = '0;
    bus.alu_fop = 4'(FOP_ADD);
    if (own) begin
      bus.alu_rda = is_div ? rs[XLEN-1:0] : acc_q;
      bus.alu_rdb = b_q;
      bus.alu_fop = is_div ? 4'(FOP_SUB) : 4'(FOP_ADD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (accept) begin
          op_q  <= bus.op;
          cnt_q <= '0;
          acc_q <= '0;
          sh_q  <= bus.op[1] ? bus.opa : bus.opb;
          b_q   <= bus.op[1] ? bus.opb : bus.opa;
          if (early) res_q <= early_res;
        end
        BUSY: begin
          acc_q <= acc_n;
          sh_q  <= sh_n;
          cnt_q <= cnt_q + 1'b1;
          // MULHU/REMU take the upper/remainder half, MUL/DIVU the shifted half
          if (last) res_q <= op_q[0] ? acc_n : sh_n;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Randomized + directed bench for alu_muldiv_seq against a plain-arithmetic reference.
module tb_alu_muldiv_seq;
  localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_muldiv_if #(.XLEN(XLEN)) bus();

  alu_muldiv_seq #(.XLEN(XLEN), .FOP_ADD(0), .FOP_SUB(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Shared ALU: combinational add/sub
  assign bus.alu_result = (bus.alu_fop == 4'd1) ? bus.alu_rda - bus.alu_rdb
                                                : bus.alu_rda + bus.alu_rdb;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
    return (EARLY && (a == 0 || b == 0)) ? 1 : 33;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit inject);
    int lat, own_cnt, wlat;
    logic [31:0] exp;
    exp = ref_model(op, a, b);
    wlat = exp_lat(a, b);
    @(negedge clk);
    lat = 0;
    while (!bus.ready && lat < 100) begin @(negedge clk); lat++; end
    chk({tag, "/ready_in"}, bus.ready, 1);
    bus.start = 1'b1; bus.op = op; bus.opa = a; bus.opb = b;
    @(posedge clk);
    lat = 1; own_cnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (inject && lat == 5) begin
        chk({tag, "/ready_busy"}, bus.ready, 0);
        bus.start = 1'b1; bus.op = ~op; bus.opa = $urandom; bus.opb = $urandom;
      end
      if (bus.done) break;
      if (bus.alu_own) own_cnt++;
      lat++;
      @(posedge clk);
    end
    chk({tag, "/latency"}, lat, wlat);
    chk({tag, "/result"}, bus.result, exp);
    chk({tag, "/own_cycles"}, own_cnt, (wlat == 1) ? 0 : 32);
    @(negedge clk);
    chk({tag, "/done_pulse"}, bus.done, 0);
    chk({tag, "/result_hold"}, bus.result, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dcnt;
    bus.start = 1'b0; bus.op = 2'd0; bus.opa = '0; bus.opb = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst/ready",   bus.ready, 1);
    chk("rst/done",    bus.done, 0);
    chk("rst/result",  bus.result, 0);
    chk("rst/alu_own", bus.alu_own, 0);
    chk("rst/alu_rda", bus.alu_rda, 0);
    chk("rst/alu_rdb", bus.alu_rdb, 0);
    chk("rst/alu_fop", bus.alu_fop, 0);

    run_op(2'd0, 32'd6, 32'd7, "mul6x7", 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff", 1'b0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_ff", 1'b0);
    run_op(2'd2, 32'd100, 32'd7, "divu100_7", 1'b0);
    run_op(2'd3, 32'd100, 32'd7, "remu100_7", 1'b0);
    run_op(2'd2, 32'd5, 32'd9, "divu5_9", 1'b0);
    run_op(2'd3, 32'd5, 32'd9, "remu5_9", 1'b0);
    run_op(2'd2, 32'h1234, 32'd0, "divu_by0", 1'b0);
    run_op(2'd3, 32'h1234, 32'd0, "remu_by0", 1'b0);
    run_op(2'd0, 32'h0001_2345, 32'h0006_789A, "mul_inject", 1'b1);
    run_op(2'd2, 32'hDEAD_BEEF, 32'h0000_0123, "divu_inject", 1'b1);

    // Reset during a divide discards it entirely
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'd2; bus.opa = 32'hDEAD_BEEF; bus.opb = 32'h1234;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst/ready",   bus.ready, 1);
    chk("midrst/done",    bus.done, 0);
    chk("midrst/result",  bus.result, 0);
    chk("midrst/alu_own", bus.alu_own, 0);
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("midrst/no_done", dcnt, 0);
    run_op(2'd0, 32'd3, 32'd3, "mul3x3", 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      run_op(op, a, b, $sformatf("rand%0d_op%0d", i, op), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
